// File: rtl/ysyx_23060203_csr_pkg.sv
// Shared CSR addresses, mstatus layout, trap codes and reset values for the WBU.
// Latency: n/a (constants and helper only).
// Backpressure: n/a.
package ysyx_23060203_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;

    // Kind of pipeline redirect carried by the instruction in the stage register.
    typedef enum logic [1:0] {
        FLUSH_NONE   = 2'd0,
        FLUSH_ECALL  = 2'd1,
        FLUSH_MRET   = 2'd2,
        FLUSH_FENCEI = 2'd3
    } flush_kind_e;

    // Only MIE/MPIE are stored; MPP is hardwired to machine mode.
    function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
        logic [31:0] v;
        v                = MSTATUS_RST;
        v[MSTATUS_MIE]   = mie;
        v[MSTATUS_MPIE]  = mpie;
        return v;
    endfunction

endpackage

// File: rtl/ysyx_23060203_csr_file.sv
// Machine CSR storage, 64-bit mcycle/minstret counters, read mux, ecall/mret side effects.
// Latency: writes/side effects land at the clock edge; reads are combinational with no bypass.
// Backpressure: none; commit/trap/mret/write strobes are already qualified by the caller.
//
// Ports: clk_i/rst_ni clock and async active-low reset; commit_i counts one retired
// instruction; csr_we_i/csr_waddr_i/csr_wdata_i plain CSR write; trap_i/trap_pc_i ecall
// entry; mret_i trap return; csr_raddr_i/csr_rdata_o decode read port; trap_vec_o and
// mepc_o feed the redirect logic.
module ysyx_23060203_csr_file
    import ysyx_23060203_csr_pkg::*;
#(
    parameter logic [31:0] MVENDORID = 32'h7973_7978,
    parameter logic [31:0] MARCHID   = 32'h015f_df6b
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        commit_i,
    input  logic        csr_we_i,
    input  logic [11:0] csr_waddr_i,
    input  logic [31:0] csr_wdata_i,
    input  logic        trap_i,
    input  logic [31:0] trap_pc_i,
    input  logic        mret_i,
    input  logic [11:0] csr_raddr_i,
    output logic [31:0] csr_rdata_o,
    output logic [31:0] trap_vec_o,
    output logic [31:0] mepc_o
);

    logic        mie_q, mie_d, mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
    logic [31:0] mcycle_lo_q, mcycle_lo_d, mcycle_hi_q, mcycle_hi_d;
    logic [31:0] minstret_lo_q, minstret_lo_d, minstret_hi_q, minstret_hi_d;

    always_comb begin
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        // Carry into the high half is taken from the pre-increment low half,
        // so a write to one half never disturbs the other half's count.
        mcycle_lo_d   = mcycle_lo_q + 32'd1;
        mcycle_hi_d   = mcycle_hi_q + {31'd0, &mcycle_lo_q};
        minstret_lo_d = minstret_lo_q + {31'd0, commit_i};
        minstret_hi_d = minstret_hi_q + {31'd0, commit_i & (&minstret_lo_q)};

        if (trap_i) begin
            mepc_d   = {trap_pc_i[31:2], 2'b00};
            mcause_d = MCAUSE_ECALL_M;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret_i) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (csr_we_i) begin
            case (csr_waddr_i)
                CSR_MSTATUS: begin
                    mie_d  = csr_wdata_i[MSTATUS_MIE];
                    mpie_d = csr_wdata_i[MSTATUS_MPIE];
                end
                CSR_MTVEC:     mtvec_d       = csr_wdata_i;
                CSR_MEPC:      mepc_d        = {csr_wdata_i[31:2], 2'b00};
                CSR_MCAUSE:    mcause_d      = csr_wdata_i;
                CSR_MCYCLE:    mcycle_lo_d   = csr_wdata_i;
                CSR_MCYCLEH:   mcycle_hi_d   = csr_wdata_i;
                CSR_MINSTRET:  minstret_lo_d = csr_wdata_i;
                CSR_MINSTRETH: minstret_hi_d = csr_wdata_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mie_q         <= MSTATUS_RST[MSTATUS_MIE];
            mpie_q        <= MSTATUS_RST[MSTATUS_MPIE];
            mtvec_q       <= '0;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mcycle_lo_q   <= '0;
            mcycle_hi_q   <= '0;
            minstret_lo_q <= '0;
            minstret_hi_q <= '0;
        end else begin
            mie_q         <= mie_d;
            mpie_q        <= mpie_d;
            mtvec_q       <= mtvec_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            mcycle_lo_q   <= mcycle_lo_d;
            mcycle_hi_q   <= mcycle_hi_d;
            minstret_lo_q <= minstret_lo_d;
            minstret_hi_q <= minstret_hi_d;
        end
    end

    always_comb begin
        csr_rdata_o = '0;
        case (csr_raddr_i)
            CSR_MSTATUS:   csr_rdata_o = mstatus_pack(mie_q, mpie_q);
            CSR_MTVEC:     csr_rdata_o = mtvec_q;
            CSR_MEPC:      csr_rdata_o = mepc_q;
            CSR_MCAUSE:    csr_rdata_o = mcause_q;
            CSR_MCYCLE:    csr_rdata_o = mcycle_lo_q;
            CSR_MCYCLEH:   csr_rdata_o = mcycle_hi_q;
            CSR_MINSTRET:  csr_rdata_o = minstret_lo_q;
            CSR_MINSTRETH: csr_rdata_o = minstret_hi_q;
            CSR_MVENDORID: csr_rdata_o = MVENDORID;
            CSR_MARCHID:   csr_rdata_o = MARCHID;
            default: ;
        endcase
    end

    // Vectored mode is not supported, so the mode bits are dropped here.
    assign trap_vec_o = {mtvec_q[31:2], 2'b00};
    assign mepc_o     = mepc_q;

endmodule

// File: rtl/ysyx_23060203_wbu.sv
// Write-back/commit stage: one-entry stage register driving the GPR port, plus flush/redirect.
// Latency: 1 cycle from accept to GPR write / flush; CSR effects at the accepting edge.
// Backpressure: in_ready_o drops only during the single flush cycle; input then is dropped.
//
// Ports: clk_i/rst_ni clock and async active-low reset; in_* execute-stage result with
// valid/ready handshake; gpr_* GPR write port; wbu_rd_o pending destination for hazards;
// csr_raddr_i/csr_rdata_o decode CSR read; flush_o/redirect_pc_o/icache_inv_o redirect.
module ysyx_23060203_wbu
    import ysyx_23060203_csr_pkg::*;
#(
    parameter logic [31:0] MVENDORID = 32'h7973_7978,
    parameter logic [31:0] MARCHID   = 32'h015f_df6b
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        in_ready_o,
    input  logic        in_valid_i,
    input  logic [31:0] in_pc_i,
    input  logic [4:0]  in_gpr_waddr_i,
    input  logic [31:0] in_gpr_wdata_i,
    input  logic        in_csr_wen_i,
    input  logic [11:0] in_csr_waddr_i,
    input  logic [31:0] in_csr_wdata_i,
    input  logic        in_exc_i,
    input  logic        in_ret_i,
    input  logic        in_fencei_i,
    output logic        gpr_wen_o,
    output logic [4:0]  gpr_waddr_o,
    output logic [31:0] gpr_wdata_o,
    output logic [4:0]  wbu_rd_o,
    input  logic [11:0] csr_raddr_i,
    output logic [31:0] csr_rdata_o,
    output logic        flush_o,
    output logic [31:0] redirect_pc_o,
    output logic        icache_inv_o
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d, wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;
    flush_kind_e kind_q, kind_d;

    logic        accept;
    logic [31:0] trap_vec, mepc;

    assign accept = in_valid_i & in_ready_o;

    always_comb begin
        valid_d = accept;
        pc_d    = pc_q;
        rd_d    = rd_q;
        wdata_d = wdata_q;
        kind_d  = kind_q;
        if (accept) begin
            pc_d    = in_pc_i;
            rd_d    = in_gpr_waddr_i;
            wdata_d = in_gpr_wdata_i;
            if (in_exc_i)         kind_d = FLUSH_ECALL;
            else if (in_ret_i)    kind_d = FLUSH_MRET;
            else if (in_fencei_i) kind_d = FLUSH_FENCEI;
            else                  kind_d = FLUSH_NONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            rd_q    <= '0;
            wdata_q <= '0;
            kind_q  <= FLUSH_NONE;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            wdata_q <= wdata_d;
            kind_q  <= kind_d;
        end
    end

    ysyx_23060203_csr_file #(
        .MVENDORID (MVENDORID),
        .MARCHID   (MARCHID)
    ) u_csr_file (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .commit_i    (accept),
        // A trap, mret or fence.i in the same instruction outranks its CSR write.
        .csr_we_i    (accept & in_csr_wen_i & ~in_exc_i & ~in_ret_i & ~in_fencei_i),
        .csr_waddr_i (in_csr_waddr_i),
        .csr_wdata_i (in_csr_wdata_i),
        .trap_i      (accept & in_exc_i),
        .trap_pc_i   (in_pc_i),
        .mret_i      (accept & in_ret_i & ~in_exc_i),
        .csr_raddr_i (csr_raddr_i),
        .csr_rdata_o (csr_rdata_o),
        .trap_vec_o  (trap_vec),
        .mepc_o      (mepc)
    );

    assign flush_o      = valid_q & (kind_q != FLUSH_NONE);
    assign icache_inv_o = valid_q & (kind_q == FLUSH_FENCEI);
    assign in_ready_o   = ~flush_o;

    assign gpr_wen_o   = valid_q & (rd_q != 5'd0);
    assign gpr_waddr_o = valid_q ? rd_q : 5'd0;
    assign gpr_wdata_o = valid_q ? wdata_q : 32'd0;
    assign wbu_rd_o    = gpr_waddr_o;

    // The CSR side effects already landed, so mtvec/mepc are read post-update.
    always_comb begin
        redirect_pc_o = '0;
        if (valid_q) begin
            case (kind_q)
                FLUSH_ECALL:  redirect_pc_o = trap_vec;
                FLUSH_MRET:   redirect_pc_o = mepc;
                FLUSH_FENCEI: redirect_pc_o = pc_q + 32'd4;
                default:      redirect_pc_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060203_wbu.sv
module tb_ysyx_23060203_wbu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_ready, in_valid;
    logic [31:0] in_pc, in_gpr_wdata, in_csr_wdata;
    logic [4:0]  in_gpr_waddr;
    logic        in_csr_wen, in_exc, in_ret, in_fencei;
    logic [11:0] in_csr_waddr, csr_raddr;
    logic        gpr_wen, flush, icache_inv;
    logic [4:0]  gpr_waddr, wbu_rd;
    logic [31:0] gpr_wdata, csr_rdata, redirect_pc;

    always #5 clk = ~clk;

    ysyx_23060203_wbu dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .in_ready_o     (in_ready),
        .in_valid_i     (in_valid),
        .in_pc_i        (in_pc),
        .in_gpr_waddr_i (in_gpr_waddr),
        .in_gpr_wdata_i (in_gpr_wdata),
        .in_csr_wen_i   (in_csr_wen),
        .in_csr_waddr_i (in_csr_waddr),
        .in_csr_wdata_i (in_csr_wdata),
        .in_exc_i       (in_exc),
        .in_ret_i       (in_ret),
        .in_fencei_i    (in_fencei),
        .gpr_wen_o      (gpr_wen),
        .gpr_waddr_o    (gpr_waddr),
        .gpr_wdata_o    (gpr_wdata),
        .wbu_rd_o       (wbu_rd),
        .csr_raddr_i    (csr_raddr),
        .csr_rdata_o    (csr_rdata),
        .flush_o        (flush),
        .redirect_pc_o  (redirect_pc),
        .icache_inv_o   (icache_inv)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } gpr_exp_t;

    typedef struct {
        logic [31:0] pc;
        logic        inv;
    } flush_exp_t;

    gpr_exp_t   gq[$];
    flush_exp_t fq[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: output seen with empty scoreboard queue", name);
    endtask

    task automatic rd_csr(input logic [11:0] addr, input logic [31:0] exp, input string name);
        csr_raddr = addr;
        #1;
        check(name, csr_rdata, exp);
    endtask

    task automatic clear_in();
        in_valid = 1'b0; in_pc = '0; in_gpr_waddr = '0; in_gpr_wdata = '0;
        in_csr_wen = 1'b0; in_csr_waddr = '0; in_csr_wdata = '0;
        in_exc = 1'b0; in_ret = 1'b0; in_fencei = 1'b0;
    endtask

    // Presents one instruction for one cycle; returns 1 time unit after the
    // accepting edge, i.e. early in the cycle where its results are visible.
    task automatic send(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] wd,
                        input logic cw, input logic [11:0] ca, input logic [31:0] cd,
                        input logic e, input logic r, input logic f);
        in_valid = 1'b1; in_pc = pc; in_gpr_waddr = rd; in_gpr_wdata = wd;
        in_csr_wen = cw; in_csr_waddr = ca; in_csr_wdata = cd;
        in_exc = e; in_ret = r; in_fencei = f;
        @(posedge clk); #1;
        clear_in();
    endtask

    task automatic csr_wr(input logic [11:0] ca, input logic [31:0] cd);
        send(32'h8000_0000, 5'd0, 32'd0, 1'b1, ca, cd, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic monitor();
        gpr_exp_t   ge;
        flush_exp_t fe;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (gpr_wen) begin
                    if (gq.size() == 0) fail_unexpected("gpr_wen");
                    else begin
                        ge = gq.pop_front();
                        check("gpr_waddr", 32'(gpr_waddr), 32'(ge.addr));
                        check("gpr_wdata", gpr_wdata, ge.data);
                        check("wbu_rd", 32'(wbu_rd), 32'(ge.addr));
                    end
                end else begin
                    check("wbu_rd idle", 32'(wbu_rd), 32'd0);
                end
                if (flush) begin
                    if (fq.size() == 0) fail_unexpected("flush");
                    else begin
                        fe = fq.pop_front();
                        check("redirect_pc", redirect_pc, fe.pc);
                        check("icache_inv", 32'(icache_inv), 32'(fe.inv));
                        check("in_ready in flush", 32'(in_ready), 32'd0);
                    end
                end else begin
                    check("icache_inv idle", 32'(icache_inv), 32'd0);
                    check("in_ready idle", 32'(in_ready), 32'd1);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_in();
        csr_raddr = '0;
        fork
            monitor();
        join_none

        // Reset state
        #12;
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst flush", 32'(flush), 32'd0);
        check("rst gpr_wen", 32'(gpr_wen), 32'd0);
        check("rst wbu_rd", 32'(wbu_rd), 32'd0);
        check("rst redirect", redirect_pc, 32'd0);
        rd_csr(12'h300, 32'h0000_1800, "rst mstatus");
        rd_csr(12'hB00, 32'd0, "rst mcycle");
        rd_csr(12'h305, 32'd0, "rst mtvec");
        #1 rst_n = 1'b1;   // t=16, one unit after a rising edge

        // GPR commits, back-to-back, and x0 suppression
        gq.push_back('{5'd5, 32'h1234});
        send(32'h8000_0000, 5'd5, 32'h1234, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        gq.push_back('{5'd6, 32'h0000_000A});
        send(32'h8000_0004, 5'd6, 32'h0000_000A, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        gq.push_back('{5'd7, 32'h0000_000B});
        send(32'h8000_0008, 5'd7, 32'h0000_000B, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        send(32'h8000_000C, 5'd0, 32'hDEAD_BEEF, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        rd_csr(12'hB02, 32'd4, "minstret after 4");
        tick();

        // CSR writes, read-only and unmapped addresses
        csr_wr(12'h305, 32'h8000_0101);
        rd_csr(12'h305, 32'h8000_0101, "mtvec");
        csr_wr(12'h300, 32'hFFFF_FFFF);
        rd_csr(12'h300, 32'h0000_1888, "mstatus mask");
        csr_wr(12'hF11, 32'h0);
        rd_csr(12'hF11, 32'h7973_7978, "mvendorid");
        rd_csr(12'hF12, 32'h015f_df6b, "marchid");
        csr_wr(12'h7C0, 32'hDEAD);
        rd_csr(12'h7C0, 32'd0, "unmapped");
        csr_wr(12'h300, 32'h0000_0008);
        rd_csr(12'h300, 32'h0000_1808, "mstatus MIE=1");

        // ecall with a competing CSR write that must be suppressed
        fq.push_back('{32'h8000_0100, 1'b0});
        send(32'h8000_0040, 5'd0, 32'd0, 1'b1, 12'h305, 32'h0, 1'b1, 1'b0, 1'b0);
        rd_csr(12'h341, 32'h8000_0040, "ecall mepc");
        rd_csr(12'h342, 32'd11, "ecall mcause");
        rd_csr(12'h300, 32'h0000_1880, "ecall mstatus");
        tick();
        rd_csr(12'h305, 32'h8000_0101, "ecall mtvec kept");

        // mret
        csr_wr(12'h341, 32'h8000_0047);
        rd_csr(12'h341, 32'h8000_0044, "mepc align");
        fq.push_back('{32'h8000_0044, 1'b0});
        send(32'h8000_0080, 5'd0, 32'd0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        rd_csr(12'h300, 32'h0000_1888, "mret mstatus");
        tick();

        // fence.i at top of address space, with input dropped in the flush cycle
        csr_wr(12'hB02, 32'd100);
        rd_csr(12'hB02, 32'd100, "minstret write");
        fq.push_back('{32'h0000_0000, 1'b1});
        send(32'hFFFF_FFFC, 5'd0, 32'd0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b1; in_gpr_waddr = 5'd9; in_gpr_wdata = 32'h99;
        @(posedge clk); #1;
        clear_in();
        rd_csr(12'hB02, 32'd101, "minstret flush drop");

        // minstret 64-bit carry
        csr_wr(12'hB82, 32'h0000_0010);
        csr_wr(12'hB02, 32'hFFFF_FFFF);
        rd_csr(12'hB82, 32'h0000_0010, "minstreth pre");
        send(32'h8000_0100, 5'd0, 32'd0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        rd_csr(12'hB02, 32'd0, "minstret wrap lo");
        rd_csr(12'hB82, 32'h0000_0011, "minstret carry hi");

        // mcycle write beats its own increment
        csr_wr(12'hB00, 32'd5);
        rd_csr(12'hB00, 32'd5, "mcycle write");
        rd_csr(12'hB80, 32'd0, "mcycleh");
        tick();

        // Reset in the middle of a pending write + flush
        send(32'h8000_0200, 5'd3, 32'h33, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("pre-reset flush", 32'(flush), 32'd1);
        check("pre-reset gpr_wen", 32'(gpr_wen), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid-reset flush", 32'(flush), 32'd0);
        check("mid-reset gpr_wen", 32'(gpr_wen), 32'd0);
        check("mid-reset in_ready", 32'(in_ready), 32'd1);
        rd_csr(12'h300, 32'h0000_1800, "mid-reset mstatus");
        rd_csr(12'h341, 32'd0, "mid-reset mepc");
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        tick();

        check("gpr queue drained", gq.size(), 32'd0);
        check("flush queue drained", fq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
